hit_memory_scheduler: RTL and testbench
=======================================

// Module: hit_memory_scheduler
// PURPOSE
//  Owns the dual-port hit-bitmap block RAM (MEMNROWS rows x WORDLENGTH bits; 1 bit per column).
//  Schedules three clients onto the RAM: streaming hit inserts, clear sweeps and readout sweeps.
//  Hit inserts are read-modify-write (port B reads, port A writes) with write forwarding.
//  Sits between the address source and the RAM primitive; exports non-empty rows on readout.
// PARAMETERS
//  ROWINDEXBITS  7    row address width
//  COLINDEXBITS  5    column-within-row width
//  WORDLENGTH    32   row width; equals 2**COLINDEXBITS
//  MEMNROWS      128  rows in use; last row is MEMNROWS-1, with MEMNROWS <= 2**ROWINDEXBITS
//  CLEARONREAD   1    1: readout zeroes each row after reading it
// PORTS
//  clock        in   1                        single clock
//  reset        in   1                        synchronous, active-high
//  hitValid     in   1                        hit address offered
//  hitAddress   in   ROWINDEXBITS+COLINDEXBITS  {row, col}
//  hitReady     out  1                        hit accepted when hitValid && hitReady
//  clearRequest in   1                        pulse; request a full clear
//  readRequest  in   1                        pulse; request a full readout
//  busy         out  1                        clear/readout sweep in progress
//  ramWeA       out  1                        port A write enable
//  ramAddrA     out  ROWINDEXBITS             port A address
//  ramDinA      out  WORDLENGTH               port A write data
//  ramAddrB     out  ROWINDEXBITS             port B (read-only) address
//  ramDoutB     in   WORDLENGTH               port B data, valid 1 cycle after address
//  rowValid     out  1                        readout row presented
//  rowIndex     out  ROWINDEXBITS             readout row number
//  rowData      out  WORDLENGTH               readout row bitmap (non-zero)
//  readDone     out  1                        1-cycle pulse, readout complete
// BEHAVIOUR
//  States: CLEAR, IDLE, READOUT. Reset (any state, mid-sweep included) -> CLEAR, row=0.
//  Reset clears pending flags, E1 and the forward register.
//  During reset: hitReady=0, busy=1, ramWeA=0, rowValid=0, readDone=0.
//  CLEAR: ramWeA=1, ramDinA=0, ramAddrA=row; row += 1 per cycle; after row MEMNROWS-1 -> IDLE.
//   Sweep lasts MEMNROWS cycles; busy=1; hitReady=0.
//  IDLE: hitReady = !clearPend && !readPend.
//   An accepted hit at cycle t drives ramAddrB=hit row combinationally in cycle t.
//   E1 <= {row, 1<<col}.
//   At t+1: ramWeA=1, ramAddrA=E1.row, ramDinA = base | E1.mask.
//   base = fwdData if fwdValid && fwdRow==E1.row, else ramDoutB.
//   fwd register <= {E1.row, ramDinA}. Throughput 1 hit/cycle; insert latency 1 cycle.
//   Hits on the same row back-to-back must accumulate; do not depend on RAM collision mode.
//  Requests: clearRequest/readRequest set sticky clearPend/readPend in any state.
//   In IDLE with E1 empty and a flag pending: go to CLEAR if clearPend (clear has priority),
//   else READOUT. Entering a sweep clears its flag and invalidates fwd.
//  READOUT: busy=1. ramAddrB=row, row 0..MEMNROWS-1, one per cycle.
//   Data returns 1 cycle later as row r.
//   If data != 0: rowValid=1, rowIndex=r, rowData=data. There is no backpressure.
//   If CLEARONREAD: ramWeA=1, ramAddrA=r, ramDinA=0 in the data-return cycle.
//   readDone pulses in the return cycle of row MEMNROWS-1; then -> IDLE.
//   readRequest in IDLE at cycle t: first address at t+1; readDone at t+MEMNROWS+1.
//  Request arriving during a sweep: serviced after the sweep ends; duplicates collapse into one.
//  Row counter ends at MEMNROWS-1; it never reaches 2**ROWINDEXBITS unless MEMNROWS equals it.
//  Outputs not active in the current state: rowValid=0, readDone=0, ramWeA=0.
// STRUCTURE
//  Parameters live in the shared MyParameters.vh include.
//  State encodings are localparams there, so siblings can decode busy phases.
//  Sub-module: row_sweep_counter (start, done at MEMNROWS-1). CLEAR and READOUT share it.
//  Forwarding/RMW logic stays inline.
// TESTING
//  Reset release: 128 cycles of ramWeA=1/ramDinA=0 at rows 0..127, then hitReady=1.
//  Hit {row 5, col 3} -> next cycle write row 5 = 0x00000008.
//  Hits at row 9, cols 0,1,2 on consecutive cycles -> final write 0x00000007.
//   No lost bits with a read-first or write-first RAM model.
//  Hits at row 2 col 4 and row 70 col 31, then readRequest -> rowValid only for 2 (0x10)
//   and 70 (0x80000000). readDone at t+129; a second readout emits nothing.
//  readRequest and clearRequest together while a hit is in E1 -> E1 written.
//   Then CLEAR, then READOUT with no rowValid; hitReady=0 throughout.
//  reset asserted mid-READOUT at row 40 -> rowValid/readDone drop that cycle; full CLEAR restarts at row 0.

Source files
------------

// File: rtl/hit_memory_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hit_memory_scheduler_pkg
//   Shared geometry of the hit-bitmap RAM, the scheduler state encoding and a
//   small helper that turns a column index into a one-hot row mask.
//   The state encoding lives here so that neighbouring blocks can decode the
//   busy phases of the scheduler without duplicating the enum.
// -----------------------------------------------------------------------------
package hit_memory_scheduler_pkg;

   localparam int ROWINDEXBITS = 7;     // row address width
   localparam int COLINDEXBITS = 5;     // column-within-row width
   localparam int WORDLENGTH   = 32;    // row width, 2**COLINDEXBITS
   localparam int MEMNROWS     = 128;   // rows in use, <= 2**ROWINDEXBITS
   localparam bit CLEARONREAD  = 1'b1;  // readout zeroes each row after reading

   localparam logic [ROWINDEXBITS-1:0] LAST_ROW = ROWINDEXBITS'(MEMNROWS - 1);

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_READOUT = 2'd2
   } sched_state_e;

   // One-hot mask selecting a single column of a row.
   function automatic logic [WORDLENGTH-1:0] col_mask(input logic [COLINDEXBITS-1:0] col);
      logic [WORDLENGTH-1:0] m;
      m      = '0;
      m[col] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hit_memory_scheduler_row_sweep_counter.sv
// -----------------------------------------------------------------------------
// hit_memory_scheduler_row_sweep_counter
//   Row counter shared by the clear and readout sweeps. It restarts at row 0
//   on start_i, advances one row per step_i and parks on the last used row,
//   so it never runs past MEMNROWS-1.
// Ports
//   clock_i   clock
//   reset_i   synchronous active-high reset, returns the counter to row 0
//   start_i   restart the sweep at row 0
//   step_i    advance one row (ignored once on the last row)
//   row_o     current row
//   last_o    current row is MEMNROWS-1
// -----------------------------------------------------------------------------
module hit_memory_scheduler_row_sweep_counter
   import hit_memory_scheduler_pkg::*;
(
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic                    step_i,
   output logic [ROWINDEXBITS-1:0] row_o,
   output logic                    last_o
);

   logic [ROWINDEXBITS-1:0] row_q;
   logic [ROWINDEXBITS-1:0] row_d;

   always_comb begin
      row_d = row_q;
      if (start_i) begin
         row_d = '0;
      end else if (step_i && (row_q != LAST_ROW)) begin
         row_d = row_q + ROWINDEXBITS'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   assign row_o  = row_q;
   assign last_o = (row_q == LAST_ROW);

endmodule

// File: rtl/hit_memory_scheduler.sv
// -----------------------------------------------------------------------------
// hit_memory_scheduler
//   Owns the dual-port hit-bitmap RAM and schedules three clients onto it:
//   streaming hit inserts (read-modify-write with write forwarding), full
//   clear sweeps and full readout sweeps that export the non-empty rows.
// Ports
//   clock, reset             clock and synchronous active-high reset
//   hitValid/hitAddress      offered hit {row, col}; hitReady accepts it
//   clearRequest/readRequest request pulses, held as sticky pending flags
//   busy                     a clear or readout sweep is running
//   ramWeA/ramAddrA/ramDinA  RAM write port
//   ramAddrB/ramDoutB        RAM read port, data one cycle after address
//   rowValid/rowIndex/rowData non-empty row presented during readout
//   readDone                 one-cycle pulse when the readout completes
// -----------------------------------------------------------------------------
module hit_memory_scheduler
   import hit_memory_scheduler_pkg::*;
(
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 hitValid,
   input  logic [ROWINDEXBITS+COLINDEXBITS-1:0] hitAddress,
   output logic                                 hitReady,
   input  logic                                 clearRequest,
   input  logic                                 readRequest,
   output logic                                 busy,
   output logic                                 ramWeA,
   output logic [ROWINDEXBITS-1:0]              ramAddrA,
   output logic [WORDLENGTH-1:0]                ramDinA,
   output logic [ROWINDEXBITS-1:0]              ramAddrB,
   input  logic [WORDLENGTH-1:0]                ramDoutB,
   output logic                                 rowValid,
   output logic [ROWINDEXBITS-1:0]              rowIndex,
   output logic [WORDLENGTH-1:0]                rowData,
   output logic                                 readDone
);

   sched_state_e            state_q;
   logic                    clear_pend_q;
   logic                    read_pend_q;
   // E1: accepted hit waiting for its read data to come back
   logic                    e1_valid_q;
   logic [ROWINDEXBITS-1:0] e1_row_q;
   logic [WORDLENGTH-1:0]   e1_mask_q;
   // Last row written by an insert; covers the RAM read that raced that write
   logic                    fwd_valid_q;
   logic [ROWINDEXBITS-1:0] fwd_row_q;
   logic [WORDLENGTH-1:0]   fwd_data_q;
   // Readout: addresses still to issue, and the row whose data returns now
   logic                    issue_q;
   logic                    ret_valid_q;
   logic [ROWINDEXBITS-1:0] ret_row_q;

   logic [ROWINDEXBITS-1:0] hit_row;
   logic [COLINDEXBITS-1:0] hit_col;
   logic                    in_idle;
   logic                    hit_accept;
   logic                    clear_want;
   logic                    read_want;
   logic                    start_sweep;
   logic                    start_clear;
   logic                    start_read;
   logic                    issue_active;
   logic                    ret_last;
   logic                    sweep_step;
   logic [ROWINDEXBITS-1:0] sweep_row;
   logic                    sweep_last;
   logic [WORDLENGTH-1:0]   rmw_base;
   logic [WORDLENGTH-1:0]   rmw_data;

   assign hit_row = hitAddress[ROWINDEXBITS+COLINDEXBITS-1 -: ROWINDEXBITS];
   assign hit_col = hitAddress[COLINDEXBITS-1:0];
   assign in_idle = (state_q == ST_IDLE);

   assign hitReady   = !reset && in_idle && !clear_pend_q && !read_pend_q;
   assign hit_accept = hitValid && hitReady;

   // A request arriving this cycle counts as pending already, so an idle
   // scheduler starts the sweep on the very next cycle. A sweep waits until
   // E1 has been written back and no hit is being taken in this cycle.
   assign clear_want  = clear_pend_q || clearRequest;
   assign read_want   = read_pend_q || readRequest;
   assign start_sweep = in_idle && !e1_valid_q && !hit_accept && (clear_want || read_want);
   assign start_clear = start_sweep && clear_want;
   assign start_read  = start_sweep && !clear_want;

   assign issue_active = (state_q == ST_READOUT) && issue_q;
   assign ret_last     = (ret_row_q == LAST_ROW);
   assign sweep_step   = (state_q == ST_CLEAR) || issue_active;

   // Back-to-back inserts on one row: the RAM read was issued before the
   // previous write landed, so take the freshly written word instead. This
   // keeps accumulation independent of the RAM's collision behaviour.
   assign rmw_base = (fwd_valid_q && (fwd_row_q == e1_row_q)) ? fwd_data_q : ramDoutB;
   assign rmw_data = rmw_base | e1_mask_q;

   hit_memory_scheduler_row_sweep_counter u_sweep (
      .clock_i (clock),
      .reset_i (reset),
      .start_i (start_sweep),
      .step_i  (sweep_step),
      .row_o   (sweep_row),
      .last_o  (sweep_last)
   );

   // RAM and readout outputs; reset forces every strobe low in its own cycle.
   always_comb begin
      busy     = reset || !in_idle;
      ramWeA   = 1'b0;
      ramAddrA = e1_row_q;
      ramDinA  = rmw_data;
      ramAddrB = hit_row;
      rowValid = 1'b0;
      rowIndex = ret_row_q;
      rowData  = ramDoutB;
      readDone = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_CLEAR: begin
               ramWeA   = 1'b1;
               ramAddrA = sweep_row;
               ramDinA  = '0;
               ramAddrB = sweep_row;
            end
            ST_IDLE: begin
               ramWeA = e1_valid_q;
            end
            ST_READOUT: begin
               ramAddrB = sweep_row;
               if (ret_valid_q) begin
                  rowValid = (ramDoutB != '0);
                  readDone = ret_last;
                  if (CLEARONREAD) begin
                     ramWeA   = 1'b1;
                     ramAddrA = ret_row_q;
                     ramDinA  = '0;
                  end
               end
            end
            default: begin
               ramWeA = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clear_pend_q <= 1'b0;
         read_pend_q  <= 1'b0;
         e1_valid_q   <= 1'b0;
         e1_row_q     <= '0;
         e1_mask_q    <= '0;
         fwd_valid_q  <= 1'b0;
         fwd_row_q    <= '0;
         fwd_data_q   <= '0;
         issue_q      <= 1'b0;
         ret_valid_q  <= 1'b0;
         ret_row_q    <= '0;
      end else begin
         // Duplicate requests collapse into the sticky flag.
         clear_pend_q <= clear_want && !start_clear;
         read_pend_q  <= read_want && !start_read;

         e1_valid_q <= hit_accept;
         if (hit_accept) begin
            e1_row_q  <= hit_row;
            e1_mask_q <= col_mask(hit_col);
         end

         // Sweeps rewrite rows behind the forwarder's back, so drop it.
         if (start_sweep) begin
            fwd_valid_q <= 1'b0;
         end else if (in_idle && e1_valid_q) begin
            fwd_valid_q <= 1'b1;
            fwd_row_q   <= e1_row_q;
            fwd_data_q  <= rmw_data;
         end

         ret_valid_q <= issue_active;
         ret_row_q   <= sweep_row;

         case (state_q)
            ST_CLEAR: begin
               if (sweep_last) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (start_clear) begin
                  state_q <= ST_CLEAR;
               end else if (start_read) begin
                  state_q <= ST_READOUT;
                  issue_q <= 1'b1;
               end
            end
            ST_READOUT: begin
               if (issue_active && sweep_last) begin
                  issue_q <= 1'b0;
               end
               // Stay one extra cycle so the last row's data can return.
               if (ret_valid_q && ret_last) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hit_memory_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hit_memory_scheduler
//   Drives hits and sweep requests into the scheduler with a behavioural RAM
//   attached. A monitor keeps a bitmap model of the hit memory: every accepted
//   hit queues the word expected on the write port, every readout request
//   queues the non-empty rows expected on the readout port.
// -----------------------------------------------------------------------------
module tb_hit_memory_scheduler;

   localparam int RB = 7;
   localparam int CB = 5;
   localparam int W  = 32;
   localparam int NR = 128;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              hitValid = 1'b0;
   logic [RB+CB-1:0]  hitAddress = '0;
   logic              hitReady;
   logic              clearRequest = 1'b0;
   logic              readRequest = 1'b0;
   logic              busy;
   logic              ramWeA;
   logic [RB-1:0]     ramAddrA;
   logic [W-1:0]      ramDinA;
   logic [RB-1:0]     ramAddrB;
   logic [W-1:0]      ramDoutB = '0;
   logic              rowValid;
   logic [RB-1:0]     rowIndex;
   logic [W-1:0]      rowData;
   logic              readDone;

   always #5 clock = ~clock;

   hit_memory_scheduler dut (
      .clock        (clock),
      .reset        (reset),
      .hitValid     (hitValid),
      .hitAddress   (hitAddress),
      .hitReady     (hitReady),
      .clearRequest (clearRequest),
      .readRequest  (readRequest),
      .busy         (busy),
      .ramWeA       (ramWeA),
      .ramAddrA     (ramAddrA),
      .ramDinA      (ramDinA),
      .ramAddrB     (ramAddrB),
      .ramDoutB     (ramDoutB),
      .rowValid     (rowValid),
      .rowIndex     (rowIndex),
      .rowData      (rowData),
      .readDone     (readDone)
   );

   // Read-first dual-port RAM: a read colliding with a write sees the old word.
   logic [W-1:0] ram [NR];
   always @(posedge clock) begin
      if (ramWeA) ram[ramAddrA] <= ramDinA;
      ramDoutB <= ram[ramAddrB];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   // ---------------- scoreboard + monitor ----------------
   typedef struct {
      int          row;
      logic [31:0] data;
   } rec_t;

   logic [W-1:0] model [NR];
   rec_t         wq[$];
   rec_t         rowq[$];
   int           doneq[$];
   int           emitted = 0;
   int           done_count = 0;
   int           done_cyc = 0;
   logic [W-1:0] last_wr_data = '0;
   int           last_wr_row = 0;
   int           m_row;
   int           m_col;
   int           m_n;
   rec_t         m_rec;

   always @(negedge clock) begin
      if (reset) begin
         wq.delete();
         rowq.delete();
         doneq.delete();
         emitted = 0;
         for (int r = 0; r < NR; r++) model[r] = '0;
      end else begin
         if (hitValid && hitReady) begin
            m_row = int'(hitAddress[RB+CB-1:CB]);
            m_col = int'(hitAddress[CB-1:0]);
            check("hit_addrB", 32'(ramAddrB), 32'(m_row));
            model[m_row] = model[m_row] | (32'd1 << m_col);
            wq.push_back('{m_row, model[m_row]});
            $display("hit     row %0d col %0d -> expect 0x%08h", m_row, m_col, model[m_row]);
         end
         if (ramWeA && !busy) begin
            if (wq.size() == 0) begin
               fail_now("hit_write_unexpected");
            end else begin
               m_rec = wq.pop_front();
               check("hit_write_row", 32'(ramAddrA), 32'(m_rec.row));
               check("hit_write_data", ramDinA, m_rec.data);
               last_wr_data = ramDinA;
               last_wr_row  = int'(ramAddrA);
            end
         end
         if (ramWeA && busy) check("sweep_write_zero", ramDinA, 32'h0);
         if (rowValid) begin
            $display("row     index %0d data 0x%08h", rowIndex, rowData);
            if (rowq.size() == 0) begin
               fail_now("rowvalid_unexpected");
            end else begin
               m_rec = rowq.pop_front();
               check("readout_index", 32'(rowIndex), 32'(m_rec.row));
               check("readout_data", rowData, m_rec.data);
            end
            emitted++;
         end
         if (readDone) begin
            $display("done    readout with %0d rows", emitted);
            if (doneq.size() == 0) fail_now("readdone_unexpected");
            else check("readout_row_count", 32'(emitted), 32'(doneq.pop_front()));
            emitted = 0;
            done_count++;
            done_cyc = cyc;
         end
         // Clear first: when both arrive together the clear is serviced first.
         if (clearRequest) begin
            for (int r = 0; r < NR; r++) model[r] = '0;
         end
         if (readRequest) begin
            m_n = 0;
            for (int r = 0; r < NR; r++) begin
               if (model[r] != '0) begin
                  rowq.push_back('{r, model[r]});
                  m_n++;
               end
               model[r] = '0;
            end
            doneq.push_back(m_n);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input int row, input int col, input logic clr, input logic rd);
      @(posedge clock);
      #1;
      hitValid     = v;
      hitAddress   = {row[RB-1:0], col[CB-1:0]};
      clearRequest = clr;
      readRequest  = rd;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic sample();
      @(negedge clock);
      #1;
   endtask

   task automatic check_clear_sweep(input string tag);
      int bad = -1;
      for (int i = 0; i < NR; i++) begin
         sample();
         if (bad < 0 && !(ramWeA === 1'b1 && ramAddrA === RB'(i) && ramDinA === '0 &&
                          busy === 1'b1 && hitReady === 1'b0)) bad = i;
      end
      check({tag, "_clear_first_bad_row"}, 32'(bad), 32'hffff_ffff);
      sample();
      check({tag, "_hitready_after_clear"}, 32'(hitReady), 32'd1);
      check({tag, "_busy_after_clear"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_done(input string tag, output int done_at);
      int start = done_count;
      bit got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         drive(1'b0, 0, 0, 1'b0, 1'b0);
         sample();
         if (done_count != start) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_readdone_seen"}, 32'(got), 32'd1);
      done_at = done_cyc;
   endtask

   int t_req;
   int t_done;
   int bad;
   bit found;
   int start_done;

   initial begin
      // Reset state
      repeat (3) @(posedge clock);
      sample();
      check("reset_hitready", 32'(hitReady), 32'd0);
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_weA", 32'(ramWeA), 32'd0);
      check("reset_rowvalid", 32'(rowValid), 32'd0);
      check("reset_readdone", 32'(readDone), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      check_clear_sweep("boot");

      // Single insert
      drive(1'b1, 5, 3, 1'b0, 1'b0);
      idle(1);
      sample();
      check("single_hit_row", 32'(last_wr_row), 32'd5);
      check("single_hit_word", last_wr_data, 32'h0000_0008);

      // Back-to-back inserts on one row must accumulate
      drive(1'b1, 9, 0, 1'b0, 1'b0);
      drive(1'b1, 9, 1, 1'b0, 1'b0);
      drive(1'b1, 9, 2, 1'b0, 1'b0);
      idle(1);
      sample();
      check("b2b_hit_word", last_wr_data, 32'h0000_0007);

      // Readout timing and content; second readout empty
      drive(1'b1, 2, 4, 1'b0, 1'b0);
      drive(1'b1, 70, 31, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      t_req = cyc;
      wait_done("readout1", t_done);
      check("readdone_latency", 32'(t_done - t_req), 32'd129);
      idle(2);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      wait_done("readout_empty", t_done);

      // Both requests while a hit sits in E1
      drive(1'b1, 11, 6, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 1'b1);
      sample();
      check("e1_drain_we", 32'(ramWeA), 32'd1);
      check("e1_drain_addr", 32'(ramAddrA), 32'd11);
      bad = 0;
      found = 1'b0;
      start_done = done_count;
      for (int i = 0; i < 400; i++) begin
         drive(1'b1, int'($urandom_range(0, NR-1)), int'($urandom_range(0, 31)), 1'b0, 1'b0);
         sample();
         if (hitReady !== 1'b0) bad++;
         if (done_count != start_done) begin
            found = 1'b1;
            break;
         end
      end
      check("clear_then_read_done", 32'(found), 32'd1);
      check("clear_then_read_hitready_cycles", 32'(bad), 32'd0);
      idle(2);

      // Reset in the middle of a readout
      drive(1'b1, 3, 1, 1'b0, 1'b0);
      drive(1'b1, 39, 7, 1'b0, 1'b0);
      drive(1'b1, 80, 2, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         drive(1'b0, 0, 0, 1'b0, 1'b0);
         sample();
         if (busy === 1'b1 && ramAddrB === RB'(39)) begin
            found = 1'b1;
            break;
         end
      end
      check("mid_readout_row39_reached", 32'(found), 32'd1);
      @(posedge clock);
      #1 reset = 1'b1;
      sample();
      check("mid_reset_rowvalid", 32'(rowValid), 32'd0);
      check("mid_reset_readdone", 32'(readDone), 32'd0);
      check("mid_reset_weA", 32'(ramWeA), 32'd0);
      check("mid_reset_busy", 32'(busy), 32'd1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check_clear_sweep("midreset");
      drive(1'b0, 0, 0, 1'b0, 1'b1);
      wait_done("after_reset_readout", t_done);

      // Random traffic, hot rows, periodic readouts and one clear
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 50; k++) begin
            int r;
            r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NR-1)) : int'($urandom_range(0, 3));
            drive(($urandom_range(0, 3) != 0), r, int'($urandom_range(0, 31)), 1'b0, 1'b0);
         end
         if (it == 3) begin
            drive(1'b0, 0, 0, 1'b1, 1'b0);
            idle(140);
         end
         drive(1'b0, 0, 0, 1'b0, 1'b1);
         wait_done("random_readout", t_done);
      end

      idle(3);
      check("hit_writes_drained", 32'(wq.size()), 32'd0);
      check("readout_rows_drained", 32'(rowq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
